vector_mask_accumulation_unit: RTL

//  Consumer stage directly downstream of the registered vector FP comparison unit (vmf[eq|ne|lt|le|gt|ge]).

---
 rtl/vector_mask_accumulation_unit.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/vector_mask_accumulation_unit.sv
// Collects per-uop FP compare result bits into one destination mask, applies
// vm/v0 masking, mask-agnostic policy and tail fill, then hands the mask to
// VRF writeback over a valid/ready handshake.
module vector_mask_accumulation_unit #(
  parameter int unsigned VLEN     = 128,
  parameter int unsigned MAX_UOPS = 8
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   flush,
  input  logic                   start_valid,
  output logic                   start_ready,
  input  logic [1:0]             start_sew,
  input  logic [3:0]             start_uops,
  input  logic [$clog2(VLEN):0]  start_vl,
  input  logic                   start_vm,
  input  logic                   start_ma,
  input  logic [VLEN-1:0]        start_v0,
  input  logic [VLEN-1:0]        start_old_vd,
  input  logic                   cmp_valid,
  output logic                   cmp_ready,
  input  logic [VLEN-1:0]        cmp_result,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [VLEN-1:0]        out_mask
);

  localparam int unsigned VlW = $clog2(VLEN) + 1;

  typedef enum logic [1:0] {StIdle, StAccum, StFinal, StDone} state_e;

  state_e          state_q, state_d;
  logic [1:0]      sew_q, sew_d;
  logic [3:0]      uops_q, uops_d;
  logic [VlW-1:0]  vl_q, vl_d;
  logic            vm_q, vm_d;
  logic            ma_q, ma_d;
  logic [VLEN-1:0] v0_q, v0_d;
  logic [VLEN-1:0] old_vd_q, old_vd_d;
  logic [VLEN-1:0] accum_q, accum_d;
  logic [3:0]      uop_idx_q, uop_idx_d;
  logic [VLEN-1:0] out_mask_q, out_mask_d;

  logic [VlW-1:0]  epu, base, limit, vl_eff;
  logic [VLEN-1:0] one_v, low_mask, wr_mask, body, sel, final_mask;

  // Element geometry of the current instruction and the final mask combine.
  always_comb begin
    one_v = {{(VLEN-1){1'b0}}, 1'b1};
    case (sew_q)
      2'd0:    epu = VlW'(VLEN / 8);
      2'd1:    epu = VlW'(VLEN / 16);
      2'd2:    epu = VlW'(VLEN / 32);
      default: epu = VlW'(VLEN / 64);
    endcase
    base     = VlW'(uop_idx_q) * epu;
    low_mask = (one_v << epu) - one_v;
    // Bits shifted past VLEN fall off, discarding out-of-range writes.
    wr_mask  = low_mask << base;
    limit    = VlW'(uops_q) * epu;
    vl_eff   = (vl_q > limit) ? limit : vl_q;
    // Shift by VLEN wraps to zero, so the subtraction yields all-ones.
    body     = (one_v << vl_eff) - one_v;
    sel      = vm_q ? {VLEN{1'b1}} : v0_q;
    final_mask = (body & sel & accum_q)
               | (body & ~sel & (ma_q ? {VLEN{1'b1}} : old_vd_q))
               | ~body;
  end

  // Next-state logic; flush overrides every handshake.
  always_comb begin
    state_d    = state_q;
    sew_d      = sew_q;
    uops_d     = uops_q;
    vl_d       = vl_q;
    vm_d       = vm_q;
    ma_d       = ma_q;
    v0_d       = v0_q;
    old_vd_d   = old_vd_q;
    accum_d    = accum_q;
    uop_idx_d  = uop_idx_q;
    out_mask_d = out_mask_q;
    unique case (state_q)
      StIdle: begin
        if (start_valid) begin
          sew_d     = start_sew;
          uops_d    = (start_uops == 4'd0 || start_uops > 4'(MAX_UOPS)) ? 4'd1 : start_uops;
          vl_d      = start_vl;
          vm_d      = start_vm;
          ma_d      = start_ma;
          v0_d      = start_v0;
          old_vd_d  = start_old_vd;
          accum_d   = '0;
          uop_idx_d = '0;
          if (start_vl == '0) begin
            out_mask_d = start_old_vd;
            state_d    = StDone;
          end else begin
            state_d = StAccum;
          end
        end
      end
      StAccum: begin
        if (cmp_valid) begin
          accum_d   = (accum_q & ~wr_mask) | ((cmp_result << base) & wr_mask);
          uop_idx_d = uop_idx_q + 4'd1;
          if (uop_idx_q == uops_q - 4'd1) state_d = StFinal;
        end
      end
      StFinal: begin
        out_mask_d = final_mask;
        state_d    = StDone;
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (flush) begin
      state_d   = StIdle;
      accum_d   = '0;
      uop_idx_d = '0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      sew_q      <= '0;
      uops_q     <= '0;
      vl_q       <= '0;
      vm_q       <= 1'b0;
      ma_q       <= 1'b0;
      v0_q       <= '0;
      old_vd_q   <= '0;
      accum_q    <= '0;
      uop_idx_q  <= '0;
      out_mask_q <= '0;
    end else begin
      state_q    <= state_d;
      sew_q      <= sew_d;
      uops_q     <= uops_d;
      vl_q       <= vl_d;
      vm_q       <= vm_d;
      ma_q       <= ma_d;
      v0_q       <= v0_d;
      old_vd_q   <= old_vd_d;
      accum_q    <= accum_d;
      uop_idx_q  <= uop_idx_d;
      out_mask_q <= out_mask_d;
    end
  end

  // Handshake outputs decode straight from state so valid never depends on ready.
  always_comb begin
    start_ready = (state_q == StIdle);
    cmp_ready   = (state_q == StAccum);
    out_valid   = (state_q == StDone);
    out_mask    = out_mask_q;
  end

endmodule
